// File: rtl/write_back_scoreboard_if.sv
// MEM/WB-side bus of the write-back scoreboard: issue claims, MEM-stage entry,
// ID source queries, register-file write port and forwarding bus.
interface write_back_scoreboard_if #(
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned REG_W = 5;

   logic              stall;
   logic              issue_valid;
   logic [REG_W-1:0]  issue_reg;
   logic              issue_ready;
   logic              mem_valid;
   logic              mem_reg_write;
   logic              mem_to_reg;
   logic [REG_W-1:0]  mem_dest;
   logic [DATA_W-1:0] mem_alu_result;
   logic [DATA_W-1:0] mem_read_data;
   logic [REG_W-1:0]  rs_addr;
   logic [REG_W-1:0]  rt_addr;
   logic              rs_busy;
   logic              rt_busy;
   logic              wb_write_enable;
   logic [REG_W-1:0]  wb_write_reg;
   logic [DATA_W-1:0] wb_write_data;
   logic              fwd_valid;
   logic [REG_W-1:0]  fwd_reg;
   logic [DATA_W-1:0] fwd_data;

   modport master (
      output stall, issue_valid, issue_reg, mem_valid, mem_reg_write, mem_to_reg,
             mem_dest, mem_alu_result, mem_read_data, rs_addr, rt_addr,
      input  issue_ready, rs_busy, rt_busy, wb_write_enable, wb_write_reg,
             wb_write_data, fwd_valid, fwd_reg, fwd_data
   );

   modport slave (
      input  stall, issue_valid, issue_reg, mem_valid, mem_reg_write, mem_to_reg,
             mem_dest, mem_alu_result, mem_read_data, rs_addr, rt_addr,
      output issue_ready, rs_busy, rt_busy, wb_write_enable, wb_write_reg,
             wb_write_data, fwd_valid, fwd_reg, fwd_data
   );
endinterface

// File: rtl/write_back_scoreboard.sv
// MIPS write-back stage: MEM/WB latch, register-file write port, forwarding bus,
// and a per-register in-flight writer scoreboard for ID-stage RAW stalls.
module write_back_scoreboard #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 2
) (
   input logic                    clk,
   input logic                    reset,
   write_back_scoreboard_if.slave bus
);
   localparam int unsigned REG_W    = 5;
   localparam int unsigned NUM_REGS = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              wb_valid_q, wb_valid_d;
   logic              wb_reg_write_q, wb_reg_write_d;
   logic [REG_W-1:0]  wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [CNT_W-1:0]  cnt_q [NUM_REGS];
   logic [CNT_W-1:0]  cnt_d [NUM_REGS];

   logic                issue_ready;
   logic                retire;
   logic                inc;
   logic                dec;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;

   // MEM/WB latch next state: hold while stalled
   always_comb begin
      wb_valid_d     = wb_valid_q;
      wb_reg_write_d = wb_reg_write_q;
      wb_dest_d      = wb_dest_q;
      wb_data_d      = wb_data_q;
      if (!bus.stall) begin
         wb_valid_d     = bus.mem_valid;
         wb_reg_write_d = bus.mem_reg_write;
         wb_dest_d      = bus.mem_dest;
         wb_data_d      = bus.mem_to_reg ? bus.mem_read_data : bus.mem_alu_result;
      end
   end

   // Scoreboard next state; a claim and a release of one register cancel out
   always_comb begin
      issue_ready = (cnt_q[bus.issue_reg] != CNT_MAX);
      retire      = wb_valid_q & ~bus.stall;
      inc         = bus.issue_valid & issue_ready & (bus.issue_reg != '0);
      dec         = retire & (wb_dest_q != '0);
      inc_vec     = '0;
      dec_vec     = '0;
      if (inc) inc_vec[bus.issue_reg] = 1'b1;
      if (dec) dec_vec[wb_dest_q] = 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         if (inc_vec[r] && !dec_vec[r]) begin
            cnt_d[r] = cnt_q[r] + CNT_W'(1);
         end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - CNT_W'(1);
         end
      end
      cnt_d[0] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_dest_q      <= '0;
         wb_data_q      <= '0;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      end else begin
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_dest_q      <= wb_dest_d;
         wb_data_q      <= wb_data_d;
         for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
`ifdef SIM
         if (dec && !inc_vec[wb_dest_q] && (cnt_q[wb_dest_q] == '0))
            $display("write_back_scoreboard: protocol error, release of idle r%0d", wb_dest_q);
`endif
      end
   end

   assign bus.issue_ready     = issue_ready;
   assign bus.rs_busy         = (cnt_q[bus.rs_addr] != '0);
   assign bus.rt_busy         = (cnt_q[bus.rt_addr] != '0);
   assign bus.wb_write_enable = retire & wb_reg_write_q & (wb_dest_q != '0);
   assign bus.wb_write_reg    = wb_dest_q;
   assign bus.wb_write_data   = wb_data_q;
   assign bus.fwd_valid       = bus.wb_write_enable;
   assign bus.fwd_reg         = wb_dest_q;
   assign bus.fwd_data        = wb_data_q;
endmodule

// File: tb/tb_write_back_scoreboard.sv
// Self-checking bench for write_back_scoreboard: directed scenarios plus a
// randomized run against a counting reference model.
module tb_write_back_scoreboard;
   localparam int unsigned DATA_W  = 32;
   localparam int          CNT_MAX = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   write_back_scoreboard_if #(.DATA_W(DATA_W)) bus();
   write_back_scoreboard #(.DATA_W(DATA_W), .CNT_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // reference model state
   int          m_cnt [32];
   bit          m_valid;
   bit          m_rw;
   int          m_dest;
   logic [31:0] m_data;

   task automatic drive_idle();
      bus.stall = 1'b0; bus.issue_valid = 1'b0; bus.issue_reg = '0;
      bus.mem_valid = 1'b0; bus.mem_reg_write = 1'b0; bus.mem_to_reg = 1'b0;
      bus.mem_dest = '0; bus.mem_alu_result = '0; bus.mem_read_data = '0;
      bus.rs_addr = '0; bus.rt_addr = '0;
   endtask

   task automatic mem_entry(input logic rw, input logic m2r, input logic [4:0] dest,
                            input logic [31:0] alu, input logic [31:0] rd);
      bus.mem_valid = 1'b1; bus.mem_reg_write = rw; bus.mem_to_reg = m2r;
      bus.mem_dest = dest; bus.mem_alu_result = alu; bus.mem_read_data = rd;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      mem_entry(1'b1, 1'b0, 5'd6, 32'h5555_AAAA, 32'h0);
      bus.issue_valid = 1'b1; bus.issue_reg = 5'd6;
      reset = 1'b1; tick(); tick();
      reset = 1'b0; drive_idle();
      bus.rs_addr = 5'd6; bus.rt_addr = 5'd31; bus.issue_reg = 5'd31;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.wb_write_enable); end
      checks++; if (bus.wb_write_reg !== 5'd0 || bus.wb_write_data !== 32'h0) begin failures++; $display("FAIL reset_wb got=%0d/%h exp=0/0", bus.wb_write_reg, bus.wb_write_data); end
      checks++; if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data} !== 38'h0) begin failures++; $display("FAIL reset_fwd got=%b/%0d/%h exp=0", bus.fwd_valid, bus.fwd_reg, bus.fwd_data); end
      checks++; if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b exp=00", bus.rs_busy, bus.rt_busy); end
      checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.issue_ready); end
      tick();
   endtask

   task automatic test_alu_path();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd5; tick();
      drive_idle(); mem_entry(1'b1, 1'b0, 5'd5, 32'h1234, 32'hFFFF); bus.rs_addr = 5'd5;
      #1;
      checks++; if (bus.rs_busy !== 1'b1) begin failures++; $display("FAIL alu_busy_after_issue got=%b exp=1", bus.rs_busy); end
      tick();
      drive_idle(); bus.rs_addr = 5'd5;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b1 || bus.wb_write_reg !== 5'd5 || bus.wb_write_data !== 32'h1234) begin failures++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/1234", bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data); end
      checks++; if (bus.fwd_valid !== 1'b1 || bus.fwd_reg !== 5'd5 || bus.fwd_data !== 32'h1234) begin failures++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/1234", bus.fwd_valid, bus.fwd_reg, bus.fwd_data); end
      tick();
      #1;
      checks++; if (bus.rs_busy !== 1'b0 || bus.wb_write_enable !== 1'b0) begin failures++; $display("FAIL alu_release got=busy%b/we%b exp=0/0", bus.rs_busy, bus.wb_write_enable); end
   endtask

   task automatic test_load_path();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd7;
      mem_entry(1'b1, 1'b1, 5'd7, 32'h1, 32'hDEAD_BEEF); tick();
      drive_idle(); bus.rt_addr = 5'd7;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b1 || bus.wb_write_reg !== 5'd7 || bus.wb_write_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_write got=%b/%0d/%h exp=1/7/deadbeef", bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data); end
      tick();
      #1;
      checks++; if (bus.rt_busy !== 1'b0) begin failures++; $display("FAIL load_release got=%b exp=0", bus.rt_busy); end
   endtask

   task automatic test_reg_zero();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd0;
      mem_entry(1'b1, 1'b0, 5'd0, 32'h55, 32'h0); tick();
      drive_idle(); bus.issue_reg = 5'd0;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b0 || bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL r0_no_write got=%b/%b exp=0/0", bus.wb_write_enable, bus.fwd_valid); end
      checks++; if (bus.wb_write_reg !== 5'd0 || bus.wb_write_data !== 32'h55) begin failures++; $display("FAIL r0_latch got=%0d/%h exp=0/55", bus.wb_write_reg, bus.wb_write_data); end
      checks++; if (bus.rs_busy !== 1'b0 || bus.issue_ready !== 1'b1) begin failures++; $display("FAIL r0_busy_ready got=%b/%b exp=0/1", bus.rs_busy, bus.issue_ready); end
      tick();
   endtask

   task automatic test_stall();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd9;
      mem_entry(1'b1, 1'b0, 5'd9, 32'h9, 32'h0); tick();
      for (int c = 0; c < 3; c++) begin
         drive_idle(); bus.stall = 1'b1; bus.rt_addr = 5'd9;
         mem_entry(1'b1, 1'b0, 5'd10, 32'hAA, 32'h0);
         #1;
         checks++; if (bus.wb_write_enable !== 1'b0 || bus.wb_write_reg !== 5'd9 || bus.rt_busy !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got=we%b/reg%0d/busy%b exp=0/9/1", c, bus.wb_write_enable, bus.wb_write_reg, bus.rt_busy); end
         tick();
      end
      drive_idle(); bus.rt_addr = 5'd9;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b1 || bus.wb_write_reg !== 5'd9 || bus.wb_write_data !== 32'h9) begin failures++; $display("FAIL stall_release_write got=%b/%0d/%h exp=1/9/9", bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data); end
      tick();
      #1;
      checks++; if (bus.rt_busy !== 1'b0 || bus.wb_write_enable !== 1'b0) begin failures++; $display("FAIL stall_after got=busy%b/we%b exp=0/0", bus.rt_busy, bus.wb_write_enable); end
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 3; c++) begin
         drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd3;
         #1;
         checks++; if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL sat_ready%0d got=%b exp=1", c, bus.issue_ready); end
         tick();
      end
      // count 3: this issue is refused and must not wrap the counter
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd3; bus.rs_addr = 5'd3;
      #1;
      checks++; if (bus.issue_ready !== 1'b0 || bus.rs_busy !== 1'b1) begin failures++; $display("FAIL sat_full got=ready%b/busy%b exp=0/1", bus.issue_ready, bus.rs_busy); end
      tick();
      drive_idle(); bus.issue_reg = 5'd3; bus.rs_addr = 5'd3;
      mem_entry(1'b1, 1'b0, 5'd3, 32'h31, 32'h0);
      #1;
      checks++; if (bus.issue_ready !== 1'b0 || bus.rs_busy !== 1'b1) begin failures++; $display("FAIL sat_no_wrap got=ready%b/busy%b exp=0/1", bus.issue_ready, bus.rs_busy); end
      tick();
      drive_idle(); bus.issue_reg = 5'd3; mem_entry(1'b1, 1'b0, 5'd3, 32'h32, 32'h0);
      #1;
      checks++; if (bus.wb_write_enable !== 1'b1 || bus.wb_write_data !== 32'h31) begin failures++; $display("FAIL sat_retire1 got=%b/%h exp=1/31", bus.wb_write_enable, bus.wb_write_data); end
      tick();
      // count 2: retire and issue of r3 in the same cycle
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd3;
      #1;
      checks++; if (bus.issue_ready !== 1'b1 || bus.wb_write_enable !== 1'b1) begin failures++; $display("FAIL sat_same_cycle got=ready%b/we%b exp=1/1", bus.issue_ready, bus.wb_write_enable); end
      tick();
      drive_idle(); bus.issue_reg = 5'd3; bus.rs_addr = 5'd3; mem_entry(1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
      #1;
      checks++; if (bus.issue_ready !== 1'b1 || bus.rs_busy !== 1'b1) begin failures++; $display("FAIL sat_count_two got=ready%b/busy%b exp=1/1", bus.issue_ready, bus.rs_busy); end
      tick();
      drive_idle(); tick();
      drive_idle(); bus.rs_addr = 5'd3; mem_entry(1'b1, 1'b0, 5'd3, 32'h34, 32'h0);
      #1;
      checks++; if (bus.rs_busy !== 1'b1) begin failures++; $display("FAIL sat_count_one got=%b exp=1", bus.rs_busy); end
      tick();
      drive_idle(); tick();
      drive_idle(); bus.rs_addr = 5'd3;
      #1;
      checks++; if (bus.rs_busy !== 1'b0) begin failures++; $display("FAIL sat_drained got=%b exp=0", bus.rs_busy); end
   endtask

   task automatic test_squash_and_reset();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd4;
      mem_entry(1'b0, 1'b0, 5'd4, 32'h44, 32'h0); tick();
      drive_idle(); bus.rs_addr = 5'd4;
      #1;
      checks++; if (bus.wb_write_enable !== 1'b0 || bus.wb_write_reg !== 5'd4 || bus.rs_busy !== 1'b1) begin failures++; $display("FAIL squash_retire got=we%b/reg%0d/busy%b exp=0/4/1", bus.wb_write_enable, bus.wb_write_reg, bus.rs_busy); end
      tick();
      #1;
      checks++; if (bus.rs_busy !== 1'b0) begin failures++; $display("FAIL squash_release got=%b exp=0", bus.rs_busy); end
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd11;
      mem_entry(1'b1, 1'b0, 5'd11, 32'h77, 32'h0); tick();
      drive_idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd12;
      mem_entry(1'b1, 1'b0, 5'd13, 32'h99, 32'h0);
      reset = 1'b1; tick();
      reset = 1'b0; drive_idle();
      bus.rs_addr = 5'd11; bus.rt_addr = 5'd12; bus.issue_reg = 5'd11;
      #1;
      checks++; if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0 || bus.issue_ready !== 1'b1) begin failures++; $display("FAIL midreset_sb got=%b%b/ready%b exp=00/1", bus.rs_busy, bus.rt_busy, bus.issue_ready); end
      checks++; if (bus.wb_write_enable !== 1'b0 || bus.wb_write_reg !== 5'd0 || bus.wb_write_data !== 32'h0) begin failures++; $display("FAIL midreset_latch got=%b/%0d/%h exp=0/0/0", bus.wb_write_enable, bus.wb_write_reg, bus.wb_write_data); end
      tick();
   endtask

   task automatic test_random();
      bit exp_retire, exp_we, exp_ready, exp_rs, exp_rt;
      int ir, dr;
      reset = 1'b1; drive_idle(); tick();
      reset = 1'b0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_valid = 0; m_rw = 0; m_dest = 0; m_data = '0;
      for (int i = 0; i < 1500; i++) begin
         bus.stall          = ($urandom_range(3) == 0);
         bus.issue_valid    = 1'($urandom_range(1));
         bus.issue_reg      = 5'($urandom_range(7));
         bus.mem_valid      = ($urandom_range(4) != 0);
         bus.mem_reg_write  = ($urandom_range(4) != 0);
         bus.mem_to_reg     = 1'($urandom_range(1));
         bus.mem_dest       = 5'($urandom_range(7));
         bus.mem_alu_result = $urandom;
         bus.mem_read_data  = $urandom;
         bus.rs_addr        = 5'($urandom_range(7));
         bus.rt_addr        = 5'($urandom_range(7));
         #1;
         exp_retire = m_valid && !bus.stall;
         exp_we     = exp_retire && m_rw && (m_dest != 0);
         exp_ready  = m_cnt[bus.issue_reg] < CNT_MAX;
         exp_rs     = m_cnt[bus.rs_addr] > 0;
         exp_rt     = m_cnt[bus.rt_addr] > 0;
         checks++; if (bus.wb_write_enable !== exp_we) begin failures++; $display("FAIL rnd_we cyc%0d got=%b exp=%b", i, bus.wb_write_enable, exp_we); end
         checks++; if (bus.wb_write_reg !== 5'(m_dest) || bus.wb_write_data !== m_data) begin failures++; $display("FAIL rnd_wb cyc%0d got=%0d/%h exp=%0d/%h", i, bus.wb_write_reg, bus.wb_write_data, m_dest, m_data); end
         checks++; if ({bus.fwd_valid, bus.fwd_reg, bus.fwd_data} !== {exp_we, 5'(m_dest), m_data}) begin failures++; $display("FAIL rnd_fwd cyc%0d got=%b/%0d/%h exp=%b/%0d/%h", i, bus.fwd_valid, bus.fwd_reg, bus.fwd_data, exp_we, m_dest, m_data); end
         checks++; if (bus.issue_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready cyc%0d r%0d got=%b exp=%b", i, bus.issue_reg, bus.issue_ready, exp_ready); end
         checks++; if (bus.rs_busy !== exp_rs || bus.rt_busy !== exp_rt) begin failures++; $display("FAIL rnd_busy cyc%0d got=%b%b exp=%b%b", i, bus.rs_busy, bus.rt_busy, exp_rs, exp_rt); end
         // advance the model: claim first, then release clamped at zero
         ir = int'(bus.issue_reg);
         if (bus.issue_valid && exp_ready && ir != 0) m_cnt[ir] = m_cnt[ir] + 1;
         dr = m_dest;
         if (exp_retire && dr != 0 && m_cnt[dr] > 0) m_cnt[dr] = m_cnt[dr] - 1;
         if (!bus.stall) begin
            m_valid = bus.mem_valid;
            m_rw    = bus.mem_reg_write;
            m_dest  = int'(bus.mem_dest);
            m_data  = bus.mem_to_reg ? bus.mem_read_data : bus.mem_alu_result;
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      tick();
      test_reset();
      test_alu_path();
      test_load_path();
      test_reg_zero();
      test_stall();
      test_saturation();
      test_squash_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
